// File: rtl/cond_unit.sv
// ARM-style condition unit: stores NZCV and evaluates each instruction's
// condition field against it. It gates the commit strobes and keeps saturating debug counters.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       flags_reg;
  logic [CNT_W-1:0] exec_reg, exec_next;
  logic [CNT_W-1:0] squash_reg, squash_next;
  logic             cond_ex;
  logic             advance;
  logic             commit;
  logic             n, z, c, v;

  assign {n, z, c, v} = flags_reg;

  // Evaluated against stored flags only, so an instruction never sees its own result
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign advance = ~reset & ~Stall;
  assign commit  = advance & cond_ex;

  assign CondEx   = cond_ex;
  assign PCSrc    = PCS & commit;
  assign RegWrite = RegW & commit & ~NoWrite;
  assign MemWrite = MemW & commit;
  assign Flags    = flags_reg;

  // FlagW[0] owns {C,V}, FlagW[1] owns {N,Z}; each half only samples ALUFlags when enabled
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
      always_ff @(posedge clk) begin
        if (reset) begin
          flags_reg[2*gi+1:2*gi] <= 2'b00;
        end else if (commit && FlagW[gi]) begin
          flags_reg[2*gi+1:2*gi] <= ALUFlags[2*gi+1:2*gi];
        end
      end
    end
  endgenerate

  always_comb begin
    exec_next   = exec_reg;
    squash_next = squash_reg;
    if (cond_ex) begin
      if (exec_reg != CNT_MAX) exec_next = exec_reg + 1'b1;
    end else begin
      if (squash_reg != CNT_MAX) squash_next = squash_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exec_reg   <= '0;
      squash_reg <= '0;
    end else if (advance) begin
      exec_reg   <= exec_next;
      squash_reg <= squash_next;
    end
  end

  assign ExecCnt   = exec_reg;
  assign SquashCnt = squash_reg;

endmodule

// File: tb/tb_cond_unit.sv
// Directed plus randomized checks of cond_unit against a behavioural NZCV model.
module tb_cond_unit;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, Stall, PCS, RegW, MemW, NoWrite;
  logic [3:0]       Cond, ALUFlags;
  logic [1:0]       FlagW;
  logic             CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCnt, SquashCnt;

  int vectors = 0;
  int miscompares = 0;

  bit [3:0] m_flags;
  int       m_exec, m_squash;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
  );

  always #5 clk = ~clk;

  // Odd codes are the negation of the preceding even code; 14 always, 15 never
  function automatic bit mcond(input bit [3:0] c, input bit [3:0] f);
    bit fn, fz, fc, fv, r;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (c >> 1)
      3'd0: r = fz;
      3'd1: r = fc;
      3'd2: r = fn;
      3'd3: r = fv;
      3'd4: r = fc && !fz;
      3'd5: r = (fn == fv);
      default: r = !fz && (fn == fv);
    endcase
    return c[0] ? !r : r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit stall, input bit [3:0] cond,
                      input logic [3:0] alu, input bit [1:0] fw,
                      input bit pcs_i, input bit regw_i, input bit memw_i, input bit nw);
    bit cex, live;
    @(negedge clk);
    reset = rst; Stall = stall; Cond = cond; ALUFlags = alu; FlagW = fw;
    PCS = pcs_i; RegW = regw_i; MemW = memw_i; NoWrite = nw;
    #1;
    cex  = mcond(cond, m_flags);
    live = !rst && !stall;
    chk("condex",   {15'd0, CondEx},   {15'd0, cex});
    chk("pcsrc",    {15'd0, PCSrc},    {15'd0, pcs_i && cex && live});
    chk("regwrite", {15'd0, RegWrite}, {15'd0, regw_i && cex && live && !nw});
    chk("memwrite", {15'd0, MemWrite}, {15'd0, memw_i && cex && live});
    chk("flags",    {12'd0, Flags},    {12'd0, m_flags});
    chk("execcnt",  16'(ExecCnt),      16'(m_exec));
    chk("squashcnt",16'(SquashCnt),    16'(m_squash));
    $display("step rst=%0b stall=%0b cond=%h alu=%h fw=%b -> condex=%0b flags=%h exec=%0d squash=%0d",
             rst, stall, cond, alu, fw, CondEx, Flags, ExecCnt, SquashCnt);
    @(posedge clk);
    if (rst) begin
      m_flags = 4'b0000; m_exec = 0; m_squash = 0;
    end else if (!stall) begin
      if (cex) begin
        if (fw[1]) m_flags[3:2] = alu[3:2];
        if (fw[0]) m_flags[1:0] = alu[1:0];
        m_exec = (m_exec < CMAX) ? m_exec + 1 : CMAX;
      end else begin
        m_squash = (m_squash < CMAX) ? m_squash + 1 : CMAX;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; Cond = 4'he; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    repeat (2) @(posedge clk);
    m_flags = 4'b0000; m_exec = 0; m_squash = 0;

    // AL after reset
    step(0, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0);
    chk("al_exec1", 16'(ExecCnt), 16'd1);

    // CMP equal, then EQ passes and NE squashes a branch
    step(0, 0, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 1);
    chk("cmp_flags", {12'd0, Flags}, 16'h0006);
    step(0, 0, 4'b0000, 4'h0, 2'b00, 0, 0, 0, 0);
    step(0, 0, 4'b0001, 4'h0, 2'b00, 1, 0, 0, 0);
    chk("ne_squash", 16'(SquashCnt), 16'd1);

    // Partial update of N,Z only
    step(0, 0, 4'b1110, 4'b1001, 2'b10, 0, 0, 0, 0);
    chk("partial_flags", {12'd0, Flags}, 16'h000a);
    step(0, 0, 4'b1010, 4'h0, 2'b00, 0, 0, 0, 0);
    step(0, 0, 4'b1011, 4'h0, 2'b00, 0, 0, 0, 0);

    // Failing instruction must not touch flags or write memory
    step(1, 0, 4'b1110, 4'h0, 2'b00, 1, 1, 1, 0);
    step(0, 0, 4'b0000, 4'b1111, 2'b11, 0, 0, 1, 0);
    chk("fail_flags", {12'd0, Flags}, 16'h0000);

    // Stall holds everything
    step(0, 1, 4'b1110, 4'b1000, 2'b11, 1, 1, 1, 0);
    chk("stall_flags", {12'd0, Flags}, 16'h0000);
    chk("stall_exec", 16'(ExecCnt), 16'd0);

    // Reset mid-sequence, with stall also asserted
    step(0, 0, 4'b1110, 4'b1010, 2'b11, 0, 0, 0, 0);
    chk("pre_reset_flags", {12'd0, Flags}, 16'h000a);
    step(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
    chk("post_reset_flags", {12'd0, Flags}, 16'h0000);
    chk("post_reset_exec", 16'(ExecCnt), 16'd0);
    chk("post_reset_squash", 16'(SquashCnt), 16'd0);

    // Undefined ALU result with no flag write
    step(0, 0, 4'b1110, 4'bxxxx, 2'b00, 0, 1, 0, 0);
    chk("x_flags", {12'd0, Flags}, 16'h0000);

    // Saturation
    repeat (20) step(0, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0);
    chk("exec_sat", 16'(ExecCnt), 16'(CMAX));
    step(0, 0, 4'b1111, 4'h0, 2'b00, 1, 1, 1, 0);
    chk("never_squash", 16'(SquashCnt), 16'd1);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
           4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer of the ALU's ALUFlags output: holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field of each instruction against it.
- Gates the decoder's write/branch strobes (PCS, RegW, MemW) so only condition-passing instructions commit.
- Keeps saturating executed/squashed instruction counters for debug.
- Sits between the main decoder, the ALU and the register file/data memory/PC-select logic of the single-cycle datapath.

Parameters:
- CNT_W, 16, width of each saturating instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Stall  input  1  hold: no flag update, no counter update, all strobes forced 0
- Cond  input  4  instruction condition field, Instr[31:28]
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  input  2  [1] = update N,Z; [0] = update C,V
- PCS  input  1  instruction writes PC (branch or Rd=R15)
- RegW  input  1  instruction writes register file
- MemW  input  1  instruction writes data memory
- NoWrite  input  1  compare-type operation (CMP/CMN/TST/TEQ): suppress register write
- CondEx  output  1  condition passed for current instruction
- PCSrc  output  1  PCS & CondEx
- RegWrite  output  1  RegW & CondEx & ~NoWrite
- MemWrite  output  1  MemW & CondEx
- Flags  output  4  current stored {N,Z,C,V}
- ExecCnt  output  CNT_W  count of condition-passing instructions
- SquashCnt  output  CNT_W  count of condition-failing instructions

Behaviour:
- Flag register, 4 bits {N,Z,C,V}. Reset value 4'b0000.
- CondEx is combinational from Cond and the stored Flags only; ALUFlags never bypasses into CondEx.
- Condition table, N/Z/C/V taken from Flags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: ~Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 0 (reserved, treated as never)
- Flag update on the rising edge when ~reset & ~Stall & CondEx:
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1].
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0].
  - Halves update independently.
  - A condition-failing instruction never modifies flags.
- Latency: flags written in cycle t are visible on Flags and CondEx in cycle t+1. An instruction sees flags from prior instructions, never its own.
- Stall = 1: Flags and counters hold. PCSrc, RegWrite and MemWrite = 0. CondEx still reflects Cond vs Flags.
- Reset = 1: PCSrc, RegWrite and MemWrite forced 0 in that cycle, independent of inputs. Flags, ExecCnt and SquashCnt <= 0 on the edge. Reset has priority over Stall.
- Counters, updated on the edge only when ~reset & ~Stall:
  - ExecCnt += 1 if CondEx.
  - SquashCnt += 1 if ~CondEx.
  - Exactly one counter advances per non-stalled cycle.
  - Each saturates at all-ones (2^CNT_W - 1) and holds; no wrap.
- X-handling: ALUFlags may be X for undefined ALU ops. With FlagW = 00, X must not reach Flags.
- Widths: counters are unsigned CNT_W. All other signals are single bits or 4-bit fields as listed.

Test Plan:
- Reset then Cond=1110 (AL), RegW=1 → CondEx=1, RegWrite=1, Flags=0000, ExecCnt=1 after one edge.
- CMP equal: ALUFlags=0110, FlagW=11, Cond=1110, NoWrite=1, RegW=1 → RegWrite=0; next cycle Flags=0110; Cond=0000 (EQ) gives CondEx=1; Cond=0001 (NE) with PCS=1 gives PCSrc=0, SquashCnt +1.
- Partial update: Flags=0110, then ALUFlags=1001, FlagW=10 → Flags=1010 (N,Z from ALU; C,V kept). GE gives CondEx=0, LT gives CondEx=1.
- Failing instruction with FlagW=11: Flags=0000, Cond=0000, ALUFlags=1111 → Flags stays 0000, MemWrite=0 with MemW=1.
- Stall and reset: Stall=1 with AL, FlagW=11, ALUFlags=1000 → Flags, counters and strobes unchanged/0. Reset asserted mid-sequence with Flags=1010 → all strobes 0 in that cycle; next cycle Flags=0000, counters 0.
- Saturation with CNT_W=4: 20 consecutive AL cycles → ExecCnt=15 held; Cond=1111 → CondEx=0, SquashCnt increments.
